case_1_sdiv_11s_7s_11_seq: RTL and testbench

// - Sequential signed integer divider; the inverse of the 7s x 7s -> 11-bit signed multiplier in the same datapath.
// - Takes an 11-bit signed dividend (a product-width value) and a 7-bit signed divisor.
// - Returns the quotient and remainder with C semantics: truncate toward zero; remainder takes the dividend's sign.
// - Radix-2, one quotient bit per cycle; valid/ready on both sides so it can replace a pipelined divider in HLS-generated datapaths.

---
 rtl/case_1_sdiv_11s_7s_11_seq_if.sv | 56 +++++
 rtl/case_1_sdiv_11s_7s_11_seq.sv | 168 ++++++++++++++++
 tb/tb_case_1_sdiv_11s_7s_11_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/case_1_sdiv_11s_7s_11_seq_if.sv
// ---------------------------------------------------------------------------
// case_1_sdiv_11s_7s_11_seq_if
// Operand/result handshake bundle for the sequential signed divider.
//
// Optional feature macro: CASE_1_SDIV_REM_EN (adds the rem signal).
//
// Signals
//   in_valid    producer -> divider  operands valid
//   in_ready    divider -> producer  divider can accept operands
//   din0        producer -> divider  dividend, signed, DIN0_W bits
//   din1        producer -> divider  divisor, signed, DIN1_W bits
//   out_valid   divider -> consumer  result valid
//   out_ready   consumer -> divider  consumer accepts result
//   dout        divider -> consumer  quotient, signed, DOUT_W bits
//   div_by_zero divider -> consumer  qualifies dout; divisor was zero
//   rem         divider -> consumer  remainder, signed, DIN1_W bits
//
// Modports
//   master : the side that supplies operands and consumes results
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface case_1_sdiv_11s_7s_11_seq_if #(
  parameter int DIN0_W = 11,
  parameter int DIN1_W = 7,
  parameter int DOUT_W = 11
);

  logic              in_valid;
  logic              in_ready;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;
  logic              div_by_zero;
`ifdef CASE_1_SDIV_REM_EN
  logic [DIN1_W-1:0] rem;
`endif

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, div_by_zero
`ifdef CASE_1_SDIV_REM_EN
    , input rem
`endif
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, div_by_zero
`ifdef CASE_1_SDIV_REM_EN
    , output rem
`endif
  );

endinterface

// File: rtl/case_1_sdiv_11s_7s_11_seq.sv
// ---------------------------------------------------------------------------
// case_1_sdiv_11s_7s_11_seq
// Sequential radix-2 signed divider with C semantics (quotient truncates
// toward zero, remainder carries the dividend's sign). One quotient bit per
// cycle, valid/ready on both sides.
//
// Optional feature macro: CASE_1_SDIV_REM_EN
//   defined   : bus.rem is driven with the signed remainder
//   undefined : no rem signal; remainder sign-fix logic is absent, the
//               partial remainder is still formed internally
//
// Ports
//   ap_clk  in   clock, rising edge
//   ap_rst  in   synchronous reset, active-high
//   bus     slave modport of case_1_sdiv_11s_7s_11_seq_if
//           (in_valid/in_ready/din0/din1, out_valid/out_ready/dout/
//            div_by_zero, rem when enabled)
//
// Timing: accept at edge T, out_valid first high after edge
// T + din0_WIDTH + 1. Divide-by-zero takes the same number of cycles.
// ---------------------------------------------------------------------------
module case_1_sdiv_11s_7s_11_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 11
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  case_1_sdiv_11s_7s_11_seq_if.slave   bus
);

  // Instance tag only; kept for identification in netlists.
  localparam int unused_id = ID;

  localparam int PR_W  = din0_WIDTH + 1;          // partial remainder width
  localparam int CNT_W = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [din0_WIDTH-1:0] quo;      // shifts dividend out, quotient bits in
  logic [PR_W-1:0]       prem;     // unsigned partial remainder
  logic [din1_WIDTH:0]   dvsr;     // |din1|
  logic                  sign_q;
  logic                  sign_r;
  logic                  dbz;
`ifdef CASE_1_SDIV_REM_EN
  logic [din1_WIDTH-1:0] din0_lo;  // raw low dividend bits for the /0 remainder
`endif

  // Magnitudes are formed one bit wider than the operand so that the most
  // negative value negates exactly.
  logic [din0_WIDTH:0] abs0;
  logic [din1_WIDTH:0] abs1;
  logic [PR_W:0]       step_val;
  logic [PR_W:0]       dvsr_ext;
  logic                step_ge;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here the first statement) so no latch can be inferred.
  always_comb begin
    abs0 = {bus.din0[din0_WIDTH-1], bus.din0};
    if (bus.din0[din0_WIDTH-1]) abs0 = -abs0;
    abs1 = {bus.din1[din1_WIDTH-1], bus.din1};
    if (bus.din1[din1_WIDTH-1]) abs1 = -abs1;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and try to subtract the divisor.
    step_val = {prem, quo[din0_WIDTH-1]};
    dvsr_ext = (PR_W+1)'(dvsr);
    step_ge  = (step_val >= dvsr_ext);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values that held before this edge.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      quo             <= '0;
      prem            <= '0;
      dvsr            <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      dbz             <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.dout        <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef CASE_1_SDIV_REM_EN
      din0_lo         <= '0;
      bus.rem         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high exactly while in IDLE.
          if (bus.in_valid) begin
            state        <= CALC;
            bus.in_ready <= 1'b0;
            cnt          <= CNT_W'(din0_WIDTH - 1);
            // {prem, quo} holds |din0| zero-extended; its top bit is always
            // zero because |din0| <= 2^(din0_WIDTH-1).
            prem         <= PR_W'(abs0[din0_WIDTH]);
            quo          <= abs0[din0_WIDTH-1:0];
            dvsr         <= abs1;
            sign_q       <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
            sign_r       <= bus.din0[din0_WIDTH-1];
            dbz          <= (bus.din1 == '0);
`ifdef CASE_1_SDIV_REM_EN
            din0_lo      <= bus.din0[din1_WIDTH-1:0];
`endif
          end
        end

        CALC: begin
          // A zero divisor skips the arithmetic but still counts out the
          // full CALC period so latency does not depend on the operands.
          if (!dbz) begin
            quo  <= {quo[din0_WIDTH-2:0], step_ge};
            prem <= step_ge ? PR_W'(step_val - dvsr_ext) : PR_W'(step_val);
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end

        FIX: begin
          if (dbz) begin
            bus.dout        <= '1;
            bus.div_by_zero <= 1'b1;
`ifdef CASE_1_SDIV_REM_EN
            bus.rem         <= din0_lo;
`endif
          end else begin
            // -(2^(W-1)) / -1 yields magnitude 2^(W-1), which reads back
            // as the most negative value: the required wrap.
            bus.dout        <= sign_q ? -quo : quo;
            bus.div_by_zero <= 1'b0;
`ifdef CASE_1_SDIV_REM_EN
            bus.rem         <= sign_r ? -prem[din1_WIDTH-1:0]
                                      :  prem[din1_WIDTH-1:0];
`endif
          end
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_1_sdiv_11s_7s_11_seq.sv
// ---------------------------------------------------------------------------
// tb_case_1_sdiv_11s_7s_11_seq
// Self-checking bench for the sequential signed divider. Expected results
// come from plain integer division in a reference function.
// ---------------------------------------------------------------------------
module tb_case_1_sdiv_11s_7s_11_seq;

  localparam int W0  = 11;
  localparam int W1  = 7;
  localparam int LAT = W0 + 1;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  case_1_sdiv_11s_7s_11_seq_if #(.DIN0_W(W0), .DIN1_W(W1), .DOUT_W(W0)) bus ();

  case_1_sdiv_11s_7s_11_seq #(
    .ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W0)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // C-style division: SV int '/' truncates toward zero and '%' takes the
  // dividend's sign; results are then cut to the port widths.
  function automatic void model(input int a, input int b,
                                output logic [W0-1:0] q,
                                output logic [W1-1:0] r,
                                output logic z);
    int qq;
    int rr;
    if (b == 0) begin
      q = '1;
      r = W1'(a);
      z = 1'b1;
    end else begin
      qq = a / b;
      rr = a % b;
      q  = W0'(qq);
      r  = W1'(rr);
      z  = 1'b0;
    end
  endfunction

  // Present operands once in_ready is seen; returns at the negedge after
  // the accept edge with garbage on din0/din1.
  task automatic start_op(input int a, input int b, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge ap_clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.din0     = W0'(a);
    bus.din1     = W1'(b);
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
    bus.din0     = W0'($urandom);
    bus.din1     = W1'($urandom);
    ok = 1'b1;
  endtask

  task automatic finish_op(input string tag, input int a, input int b,
                           input int hold);
    logic [W0-1:0] eq;
    logic [W1-1:0] er;
    logic          ez;
    int            lat;
    bit            dev;
    model(a, b, eq, er, ez);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_dout"}, bus.dout, eq);
    check({tag, "_dbz"}, bus.div_by_zero, ez);
`ifdef CASE_1_SDIV_REM_EN
    check({tag, "_rem"}, bus.rem, er);
`endif
    dev = 1'b0;
    repeat (hold) begin
      @(negedge ap_clk);
      if (bus.dout !== eq || bus.div_by_zero !== ez ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) dev = 1'b1;
`ifdef CASE_1_SDIV_REM_EN
      if (bus.rem !== er) dev = 1'b1;
`endif
    end
    if (hold > 0) check({tag, "_hold_stable"}, {31'd0, dev}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge ap_clk);
    bus.out_ready = 1'b0;
    check({tag, "_released"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input int hold);
    bit ok;
    start_op(a, b, ok);
    if (ok) begin
      check({tag, "_in_ready_drop"}, {31'd0, bus.in_ready}, 32'd0);
      finish_op(tag, a, b, hold);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_dout"}, bus.dout, '0);
    check({tag, "_dbz"}, bus.div_by_zero, 1'b0);
`ifdef CASE_1_SDIV_REM_EN
    check({tag, "_rem"}, bus.rem, '0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int  a;
    int  b;
    int  hold;
    bit  ok;
    bit  saw_valid;

    ap_rst        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    repeat (3) @(negedge ap_clk);
    check_reset_values("reset");
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Directed cases, including sign combinations and boundaries.
    run_op("p100_p7",     100,    7,  0);
    run_op("n100_p7",    -100,    7,  0);
    run_op("p100_n7",     100,   -7,  0);
    run_op("n100_n7",    -100,   -7,  0);
    run_op("min_n1",    -1024,   -1,  0);
    run_op("min_min1",  -1024,  -64,  0);
    run_op("p5_zero",       5,    0, 20);
    run_op("max_n64",    1023,  -64,  0);
    run_op("min_p63",   -1024,   63,  3);
    run_op("n1_n64",       -1,  -64,  0);
    run_op("nzero_zero", -700,    0,  0);

    // Randomized back-to-back operations.
    for (int i = 0; i < 30; i++) begin
      a    = $signed(W0'($urandom));
      b    = (i % 7 == 3) ? 0 : $signed(W1'($urandom));
      hold = (i % 5 == 0) ? int'($urandom_range(1, 6)) : 0;
      run_op($sformatf("rand%0d", i), a, b, hold);
    end

    // Reset in the middle of CALC: result discarded, in_valid ignored.
    start_op(-100, 7, ok);
    if (ok) begin
      repeat (4) @(negedge ap_clk);
      ap_rst       = 1'b1;
      bus.in_valid = 1'b1;
      bus.din0     = W0'(3);
      bus.din1     = W1'(1);
      @(negedge ap_clk);
      check_reset_values("midreset");
      ap_rst       = 1'b0;
      bus.in_valid = 1'b0;
      saw_valid    = 1'b0;
      repeat (20) begin
        @(negedge ap_clk);
        if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
      end
      check("midreset_no_result", {31'd0, saw_valid}, 32'd0);
      check("midreset_idle", {31'd0, bus.in_ready}, 32'd1);
    end
    run_op("after_reset_n7_p2", -7, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
